// File: rtl/snn_sched_pkg.sv
// Shared types and constants for the SNN layer scheduler: FSM state encoding,
// error codes and the default neuron-count / class widths.
package snn_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_READ,
        ST_ARGMAX,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CFG     = 2'd1;
    localparam logic [1:0] ERR_ARRAY   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam int NRN_W_DEF = 7;
    localparam int CLS_W_DEF = 2;

endpackage

// File: rtl/snn_layer_mask_gen.sv
// Thermometer masks for a layer of 'count' neurons: one PE per neuron, and
// every array that holds at least one active PE (4 PEs per array).
module snn_layer_mask_gen
    import snn_sched_pkg::*;
#(
    parameter int NUM_ARRAYS = 16,
    parameter int NRN_W      = NRN_W_DEF
) (
    input  logic [NRN_W-1:0]        count,
    output logic [4*NUM_ARRAYS-1:0] pe_mask,
    output logic [NUM_ARRAYS-1:0]   array_mask
);

    always_comb begin
        pe_mask    = '0;
        array_mask = '0;
        for (int k = 0; k < 4 * NUM_ARRAYS; k++) begin
            pe_mask[k] = (k < int'(count));
        end
        for (int i = 0; i < NUM_ARRAYS; i++) begin
            array_mask[i] = ((4 * i) < int'(count));
        end
    end

endmodule

// File: rtl/snn_layer_scheduler.sv
// Descriptor-driven layer sequencer: walks the layer table per inference, drives
// array/PE enables, offsets and broadcast start, then readback and ArgMax.
module snn_layer_scheduler
    import snn_sched_pkg::*;
#(
    parameter int NUM_LAYERS = 3,
    parameter int NUM_ARRAYS = 16,
    parameter int ADDR_W     = 10,
    parameter int TIME_W     = 8,
    parameter int NRN_W      = NRN_W_DEF,
    parameter int TMO_W      = 16,
    parameter int CLS_W      = CLS_W_DEF
) (
    input  logic                          local_clk,
    input  logic                          rst,
    input  logic                          i_cfg_we,
    input  logic [$clog2(NUM_LAYERS)-1:0] i_cfg_layer,
    input  logic [NRN_W-1:0]              i_cfg_neurons,
    input  logic [ADDR_W-1:0]             i_cfg_offset,
    input  logic [TIME_W-1:0]             i_cfg_t_min,
    input  logic                          i_start,
    input  logic                          i_abort,
    input  logic                          i_layer_done,
    input  logic [NUM_ARRAYS-1:0]         i_array_error,
    input  logic                          i_argmax_valid,
    input  logic [CLS_W-1:0]              i_argmax_class,
    output logic [NUM_ARRAYS-1:0]         o_array_clk_en,
    output logic [4*NUM_ARRAYS-1:0]       o_pe_enable,
    output logic [NUM_ARRAYS-1:0]         o_reset_potential,
    output logic [ADDR_W-1:0]             o_bram_offset,
    output logic [TIME_W-1:0]             o_t_min,
    output logic                          o_src_sel,
    output logic                          o_bcast_start,
    output logic [NRN_W-1:0]              o_bcast_count,
    output logic                          o_rd_valid,
    output logic [NRN_W-1:0]              o_rd_idx,
    output logic                          o_rd_last,
    output logic [$clog2(NUM_LAYERS)-1:0] o_layer,
    output logic                          o_argmax_start,
    output logic                          o_done,
    output logic [CLS_W-1:0]              o_class,
    output logic                          o_error,
    output logic [1:0]                    o_err_code,
    output state_t                        o_state
);

    localparam int LAYER_W = $clog2(NUM_LAYERS);
    localparam int PE_W    = 4 * NUM_ARRAYS;

    logic [NRN_W-1:0]  desc_n   [NUM_LAYERS];
    logic [ADDR_W-1:0] desc_off [NUM_LAYERS];
    logic [TIME_W-1:0] desc_tmin[NUM_LAYERS];

    state_t              state_q, state_d;
    logic [LAYER_W-1:0]  layer_d;
    logic [NRN_W-1:0]    cur_n_q, cur_n_d, sel_n, idx_inc;
    logic [TMO_W-1:0]    wdog_q, wdog_d, wdog_inc;
    logic [PE_W-1:0]     load_pe, pe_en_d;
    logic [NUM_ARRAYS-1:0] load_arr, arr_en_d, reset_pot_d;
    logic [ADDR_W-1:0]   offset_d;
    logic [TIME_W-1:0]   t_min_d;
    logic [NRN_W-1:0]    bcast_count_d, rd_idx_d;
    logic [CLS_W-1:0]    class_d;
    logic [1:0]          err_code_d, err_sel;
    logic                src_sel_d, bcast_start_d, rd_valid_d, rd_last_d;
    logic                argmax_start_d, done_d, error_d, err_hit, go_idle, n_bad;

    assign o_state  = state_q;
    assign sel_n    = desc_n[o_layer];
    assign idx_inc  = o_rd_idx + NRN_W'(1);
    assign wdog_inc = wdog_q + TMO_W'(1);
    assign n_bad    = (sel_n == '0) || (int'(sel_n) > PE_W);

    snn_layer_mask_gen #(
        .NUM_ARRAYS (NUM_ARRAYS),
        .NRN_W      (NRN_W)
    ) u_mask_gen (
        .count      (sel_n),
        .pe_mask    (load_pe),
        .array_mask (load_arr)
    );

    // Descriptor table is only writable while idle and deliberately survives rst.
    always_ff @(posedge local_clk) begin
        if (i_cfg_we && state_q == ST_IDLE && int'(i_cfg_layer) < NUM_LAYERS) begin
            desc_n[i_cfg_layer]    <= i_cfg_neurons;
            desc_off[i_cfg_layer]  <= i_cfg_offset;
            desc_tmin[i_cfg_layer] <= i_cfg_t_min;
        end
    end

    always_comb begin
        state_d        = state_q;
        layer_d        = o_layer;
        cur_n_d        = cur_n_q;
        wdog_d         = wdog_q;
        arr_en_d       = o_array_clk_en;
        pe_en_d        = o_pe_enable;
        offset_d       = o_bram_offset;
        t_min_d        = o_t_min;
        src_sel_d      = o_src_sel;
        bcast_start_d  = 1'b0;
        bcast_count_d  = o_bcast_count;
        rd_valid_d     = o_rd_valid;
        rd_idx_d       = o_rd_idx;
        rd_last_d      = o_rd_last;
        argmax_start_d = 1'b0;
        done_d         = o_done;
        class_d        = o_class;
        error_d        = o_error;
        err_code_d     = o_err_code;
        reset_pot_d    = '0;
        err_hit        = 1'b0;
        err_sel        = ERR_NONE;
        go_idle        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_LOAD;
                    layer_d = '0;
                end
            end
            ST_LOAD: begin
                if (n_bad) begin
                    err_hit = 1'b1;
                    err_sel = ERR_CFG;
                end else begin
                    state_d       = ST_RUN;
                    pe_en_d       = load_pe;
                    arr_en_d      = load_arr;
                    offset_d      = desc_off[o_layer];
                    t_min_d       = desc_tmin[o_layer];
                    src_sel_d     = (o_layer != '0);
                    bcast_start_d = (o_layer != '0);
                    // cur_n_q still holds the previous layer's count here.
                    bcast_count_d = (o_layer != '0) ? cur_n_q : '0;
                    cur_n_d       = sel_n;
                    wdog_d        = '0;
                end
            end
            ST_RUN: begin
                wdog_d = wdog_inc;
                if (|i_array_error) begin
                    err_hit = 1'b1;
                    err_sel = ERR_ARRAY;
                end else if (&wdog_inc) begin
                    err_hit = 1'b1;
                    err_sel = ERR_TIMEOUT;
                end else if (i_layer_done) begin
                    state_d    = ST_READ;
                    rd_valid_d = 1'b1;
                    rd_idx_d   = '0;
                    rd_last_d  = (cur_n_q == NRN_W'(1));
                end
            end
            ST_READ: begin
                if (|i_array_error) begin
                    err_hit = 1'b1;
                    err_sel = ERR_ARRAY;
                end else if (o_rd_last) begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                    if (o_layer == LAYER_W'(NUM_LAYERS - 1)) begin
                        state_d        = ST_ARGMAX;
                        argmax_start_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD;
                        layer_d = o_layer + LAYER_W'(1);
                    end
                end else begin
                    rd_idx_d  = idx_inc;
                    rd_last_d = (idx_inc == cur_n_q - NRN_W'(1));
                end
            end
            // ArgMax handshake: o_argmax_start pulses once on entry; the unit answers
            // with a single-cycle i_argmax_valid carrying i_argmax_class, no back-pressure.
            ST_ARGMAX: begin
                if (i_argmax_valid) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                    class_d = i_argmax_class;
                end
            end
            ST_DONE: begin
                if (!i_start) go_idle = 1'b1;
            end
            ST_ERROR: begin
            end
            default: go_idle = 1'b1;
        endcase

        if (err_hit) begin
            state_d    = ST_ERROR;
            error_d    = 1'b1;
            err_code_d = err_sel;
            arr_en_d   = '0;
            pe_en_d    = '0;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
        end

        if (go_idle || i_abort) begin
            state_d        = ST_IDLE;
            layer_d        = '0;
            arr_en_d       = '0;
            pe_en_d        = '0;
            offset_d       = '0;
            t_min_d        = '0;
            src_sel_d      = 1'b0;
            bcast_start_d  = 1'b0;
            bcast_count_d  = '0;
            rd_valid_d     = 1'b0;
            rd_idx_d       = '0;
            rd_last_d      = 1'b0;
            argmax_start_d = 1'b0;
            done_d         = 1'b0;
            class_d        = '0;
            error_d        = 1'b0;
            err_code_d     = ERR_NONE;
        end

        reset_pot_d = (state_d == ST_IDLE) ? '1 : '0;
    end

    always_ff @(posedge local_clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            cur_n_q           <= '0;
            wdog_q            <= '0;
            o_layer           <= '0;
            o_array_clk_en    <= '0;
            o_pe_enable       <= '0;
            o_reset_potential <= '1;
            o_bram_offset     <= '0;
            o_t_min           <= '0;
            o_src_sel         <= 1'b0;
            o_bcast_start     <= 1'b0;
            o_bcast_count     <= '0;
            o_rd_valid        <= 1'b0;
            o_rd_idx          <= '0;
            o_rd_last         <= 1'b0;
            o_argmax_start    <= 1'b0;
            o_done            <= 1'b0;
            o_class           <= '0;
            o_error           <= 1'b0;
            o_err_code        <= ERR_NONE;
        end else begin
            state_q           <= state_d;
            cur_n_q           <= cur_n_d;
            wdog_q            <= wdog_d;
            o_layer           <= layer_d;
            o_array_clk_en    <= arr_en_d;
            o_pe_enable       <= pe_en_d;
            o_reset_potential <= reset_pot_d;
            o_bram_offset     <= offset_d;
            o_t_min           <= t_min_d;
            o_src_sel         <= src_sel_d;
            o_bcast_start     <= bcast_start_d;
            o_bcast_count     <= bcast_count_d;
            o_rd_valid        <= rd_valid_d;
            o_rd_idx          <= rd_idx_d;
            o_rd_last         <= rd_last_d;
            o_argmax_start    <= argmax_start_d;
            o_done            <= done_d;
            o_class           <= class_d;
            o_error           <= error_d;
            o_err_code        <= err_code_d;
        end
    end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
// Bench for snn_layer_scheduler: directed and randomized inferences checked against
// a descriptor-table model of masks, offsets, readback and error behaviour.
module tb_snn_layer_scheduler;
    import snn_sched_pkg::*;

    localparam int NL  = 3;
    localparam int NA  = 16;
    localparam int AW  = 10;
    localparam int TW  = 8;
    localparam int NW  = 7;
    localparam int TMO = 8;
    localparam int CW  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_cfg_we = 1'b0;
    logic [1:0]    i_cfg_layer = '0;
    logic [NW-1:0] i_cfg_neurons = '0;
    logic [AW-1:0] i_cfg_offset = '0;
    logic [TW-1:0] i_cfg_t_min = '0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic          i_layer_done = 1'b0;
    logic [NA-1:0] i_array_error = '0;
    logic          i_argmax_valid = 1'b0;
    logic [CW-1:0] i_argmax_class = '0;

    logic [NA-1:0]   o_array_clk_en, o_reset_potential;
    logic [4*NA-1:0] o_pe_enable;
    logic [AW-1:0]   o_bram_offset;
    logic [TW-1:0]   o_t_min;
    logic            o_src_sel, o_bcast_start, o_rd_valid, o_rd_last;
    logic [NW-1:0]   o_bcast_count, o_rd_idx;
    logic [1:0]      o_layer, o_err_code;
    logic            o_argmax_start, o_done, o_error;
    logic [CW-1:0]   o_class;
    state_t          o_state;

    int total = 0;
    int bad   = 0;
    int m_n[NL], m_off[NL], m_tmin[NL];
    bit aborted;

    snn_layer_scheduler #(
        .NUM_LAYERS(NL), .NUM_ARRAYS(NA), .ADDR_W(AW), .TIME_W(TW),
        .NRN_W(NW), .TMO_W(TMO), .CLS_W(CW)
    ) dut (
        .local_clk(clk), .rst(rst),
        .i_cfg_we(i_cfg_we), .i_cfg_layer(i_cfg_layer), .i_cfg_neurons(i_cfg_neurons),
        .i_cfg_offset(i_cfg_offset), .i_cfg_t_min(i_cfg_t_min),
        .i_start(i_start), .i_abort(i_abort), .i_layer_done(i_layer_done),
        .i_array_error(i_array_error), .i_argmax_valid(i_argmax_valid),
        .i_argmax_class(i_argmax_class),
        .o_array_clk_en(o_array_clk_en), .o_pe_enable(o_pe_enable),
        .o_reset_potential(o_reset_potential), .o_bram_offset(o_bram_offset),
        .o_t_min(o_t_min), .o_src_sel(o_src_sel), .o_bcast_start(o_bcast_start),
        .o_bcast_count(o_bcast_count), .o_rd_valid(o_rd_valid), .o_rd_idx(o_rd_idx),
        .o_rd_last(o_rd_last), .o_layer(o_layer), .o_argmax_start(o_argmax_start),
        .o_done(o_done), .o_class(o_class), .o_error(o_error),
        .o_err_code(o_err_code), .o_state(o_state)
    );

    // clock / global time limit
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    // reference model: masks from the neuron count by plain arithmetic
    function automatic logic [63:0] pe_model(input int n);
        if (n >= 4 * NA) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    function automatic logic [63:0] arr_model(input int n);
        int groups;
        groups = (n + 3) / 4;
        return (64'd1 << groups) - 64'd1;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int l, input int n, input int off, input int tmin);
        i_cfg_we      = 1'b1;
        i_cfg_layer   = 2'(l);
        i_cfg_neurons = 7'(n);
        i_cfg_offset  = 10'(off);
        i_cfg_t_min   = 8'(tmin);
        tick();
        i_cfg_we      = 1'b0;
    endtask

    task automatic program_layer(input int l, input int n, input int off, input int tmin);
        m_n[l] = n; m_off[l] = off; m_tmin[l] = tmin;
        cfg_write(l, n, off, tmin);
    endtask

    task automatic enter_run(input int l);
        tick();
        check($sformatf("pe_en_l%0d", l), 64'(o_pe_enable), pe_model(m_n[l]));
        check($sformatf("arr_en_l%0d", l), 64'(o_array_clk_en), arr_model(m_n[l]));
        check($sformatf("offset_l%0d", l), 64'(o_bram_offset), 64'(m_off[l]));
        check($sformatf("t_min_l%0d", l), 64'(o_t_min), 64'(m_tmin[l]));
        check($sformatf("src_sel_l%0d", l), 64'(o_src_sel), 64'(l != 0));
        check($sformatf("layer_l%0d", l), 64'(o_layer), 64'(l));
        check($sformatf("bcast_start_l%0d", l), 64'(o_bcast_start), 64'(l != 0));
        check($sformatf("reset_pot_l%0d", l), 64'(o_reset_potential), 64'(0));
        if (l != 0) check($sformatf("bcast_count_l%0d", l), 64'(o_bcast_count), 64'(m_n[l-1]));
    endtask

    task automatic finish_run(input int d);
        for (int c = 1; c < d; c++) begin
            tick();
            if (c == 1) check("bcast_pulse_clear", 64'(o_bcast_start), 64'(0));
        end
        i_layer_done = 1'b1;
        tick();
        i_layer_done = 1'b0;
    endtask

    task automatic abort_to_idle(input string tag);
        i_start = 1'b0;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        check({tag, "_error"}, 64'(o_error), 64'(0));
        check({tag, "_code"}, 64'(o_err_code), 64'(ERR_NONE));
        check({tag, "_reset_pot"}, 64'(o_reset_potential), 64'(16'hFFFF));
        check({tag, "_layer"}, 64'(o_layer), 64'(0));
        check({tag, "_rd_valid"}, 64'(o_rd_valid), 64'(0));
        check({tag, "_pe_en"}, 64'(o_pe_enable), 64'(0));
        check({tag, "_state"}, 64'(o_state), 64'(ST_IDLE));
    endtask

    task automatic do_reads(input int l, input int abort_at, output bit ab);
        ab = 1'b0;
        for (int i = 0; i < m_n[l]; i++) begin
            if (i == abort_at) begin
                abort_to_idle("abort_read");
                ab = 1'b1;
                return;
            end
            check($sformatf("rd_valid_l%0d_%0d", l, i), 64'(o_rd_valid), 64'(1));
            check($sformatf("rd_idx_l%0d_%0d", l, i), 64'(o_rd_idx), 64'(i));
            check($sformatf("rd_last_l%0d_%0d", l, i), 64'(o_rd_last), 64'(i == m_n[l] - 1));
            tick();
        end
        check($sformatf("rd_end_l%0d", l), 64'(o_rd_valid), 64'(0));
    endtask

    task automatic run_inference(input int dmin, input int dmax, input logic [CW-1:0] cls);
        i_start = 1'b1;
        tick();
        for (int l = 0; l < NL; l++) begin
            enter_run(l);
            finish_run(int'($urandom_range(dmax, dmin)));
            do_reads(l, -1, aborted);
        end
        check("argmax_start", 64'(o_argmax_start), 64'(1));
        i_argmax_valid = 1'b1;
        i_argmax_class = cls;
        tick();
        i_argmax_valid = 1'b0;
        check("done", 64'(o_done), 64'(1));
        check("class", 64'(o_class), 64'(cls));
        check("argmax_pulse_clear", 64'(o_argmax_start), 64'(0));
        tick();
        check("done_held", 64'(o_done), 64'(1));
        check("class_held", 64'(o_class), 64'(cls));
        i_start = 1'b0;
        tick();
        check("idle_done", 64'(o_done), 64'(0));
        check("idle_reset_pot", 64'(o_reset_potential), 64'(16'hFFFF));
    endtask

    // directed steps
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        check("rst_pe_en", 64'(o_pe_enable), 64'(0));
        check("rst_arr_en", 64'(o_array_clk_en), 64'(0));
        check("rst_reset_pot", 64'(o_reset_potential), 64'(16'hFFFF));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_error", 64'(o_error), 64'(0));
        check("rst_rd_valid", 64'(o_rd_valid), 64'(0));
        check("rst_layer", 64'(o_layer), 64'(0));
        check("rst_state", 64'(o_state), 64'(ST_IDLE));

        program_layer(0, 64, 0, 0);
        program_layer(1, 32, 160, 20);
        program_layer(2, 3, 224, 40);
        run_inference(5, 5, 2'd2);

        program_layer(0, 1, 17, 3);
        program_layer(1, 4, 512, 127);
        program_layer(2, 5, 1023, 255);
        run_inference(1, 3, 2'd1);

        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < NL; l++)
                program_layer(l, int'($urandom_range(64, 1)), int'($urandom_range(1023, 0)),
                              int'($urandom_range(255, 0)));
            run_inference(1, 6, 2'($urandom_range(3, 0)));
        end

        program_layer(0, int'($urandom_range(64, 1)), 5, 6);
        program_layer(1, 0, 7, 8);
        i_start = 1'b1;
        tick();
        enter_run(0);
        finish_run(2);
        do_reads(0, -1, aborted);
        tick();
        check("cfg_err_error", 64'(o_error), 64'(1));
        check("cfg_err_code", 64'(o_err_code), 64'(ERR_CFG));
        check("cfg_err_pe_en", 64'(o_pe_enable), 64'(0));
        check("cfg_err_arr_en", 64'(o_array_clk_en), 64'(0));
        tick();
        check("cfg_err_sticky", 64'(o_error), 64'(1));
        abort_to_idle("cfg_err_abort");

        program_layer(0, 8, 1, 2);
        i_start = 1'b1;
        tick();
        enter_run(0);
        repeat ((1 << TMO) - 2) tick();
        check("tmo_not_yet", 64'(o_error), 64'(0));
        tick();
        check("tmo_error", 64'(o_error), 64'(1));
        check("tmo_code", 64'(o_err_code), 64'(ERR_TIMEOUT));
        check("tmo_pe_en", 64'(o_pe_enable), 64'(0));
        abort_to_idle("tmo_abort");

        program_layer(0, int'($urandom_range(64, 1)), 9, 10);
        i_start = 1'b1;
        tick();
        enter_run(0);
        tick();
        i_array_error = 16'h0020;
        i_layer_done  = 1'b1;
        tick();
        i_array_error = '0;
        i_layer_done  = 1'b0;
        check("arr_err_error", 64'(o_error), 64'(1));
        check("arr_err_code", 64'(o_err_code), 64'(ERR_ARRAY));
        check("arr_err_rd_valid", 64'(o_rd_valid), 64'(0));
        check("arr_err_arr_en", 64'(o_array_clk_en), 64'(0));
        abort_to_idle("arr_err_abort");

        for (int l = 0; l < NL; l++)
            program_layer(l, int'($urandom_range(64, 2)), int'($urandom_range(1023, 0)),
                          int'($urandom_range(255, 0)));
        i_start = 1'b1;
        tick();
        enter_run(0);
        cfg_write(2, (m_n[2] % 64) + 1, m_off[2] ^ 1, m_tmin[2] ^ 8'h55);
        finish_run(3);
        do_reads(0, -1, aborted);
        enter_run(1);
        finish_run(2);
        do_reads(1, -1, aborted);
        enter_run(2);
        finish_run(2);
        do_reads(2, 1, aborted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
